mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's data/instruction bus. The CPU is the initiator; this block serves its read and write requests.
- Accepts one request at a time over a req/ack handshake.
- Adds a configurable wait-state latency.
- Performs byte and halfword stores into a word-wide synchronous array via read-modify-write.
- Drives read data back to the instruction register / MDR path.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, ≥4).
- LATENCY, 1, wait-state cycles inserted before the array access (≥1).

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request valid; level, held by initiator until ack.
- wr  input  1  1 = write, 0 = read; sampled with req.
- Address  input  32  byte address.
- Datain  input  32  write data; sub-word values right-justified (byte in [7:0], halfword in [15:0]).
- size  input  2  store size: 0 = word, 1 = byte, 2 = halfword, 3 = reserved (treated as word).
- Dataout  output  32  read data; valid while ack=1, held until the next ack.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state ≠ IDLE.
- err  output  1  misalignment flag, valid with ack (see Optional Feature); otherwise 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, busy=0, err=0, Dataout=0, latency counter=0. Array contents are not cleared. A reset asserted mid-transaction aborts it; a write not yet committed is dropped.
- Word index = Address[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- Lane order is little-endian: byte lane = Address[1:0] (lane 0 = bits [7:0]). Halfword lane = Address[1] (0 = bits [15:0]).
- FSM states: IDLE, WAIT, ACCESS, MERGE, RESP.
- IDLE:
  - If req=1: capture wr, Address, Datain, size; load counter with LATENCY-1; go to WAIT.
  - req is sampled only in IDLE.
- WAIT: decrement counter each cycle. When counter=0, go to ACCESS.
- ACCESS:
  - Read or sub-word write: issue synchronous array read; data is registered at this edge.
  - Word write: commit Datain to the array at this edge.
  - Sub-word write goes to MERGE; all other accesses go to RESP.
- MERGE:
  - Replace the selected byte/halfword lane of the registered read word with the captured Datain low bits.
  - Write the merged word back at this edge; go to RESP.
- RESP:
  - ack=1 for exactly one cycle.
  - Dataout is loaded with the full registered word on reads; on writes Dataout is left unchanged.
  - Go to IDLE.
- Reads always return the full 32-bit word; size is ignored on reads. Sub-word extraction belongs to the CPU.
- Latency: ack is high in the cycle after edge LATENCY+1 counted from the accept edge (edge 0) for reads and word writes, and after edge LATENCY+2 for byte/halfword writes. With LATENCY=1, a read acks 3 cycles after req is first seen.
- Back-to-back requests: if req is still 1 in the IDLE cycle following ack, it is accepted as a new request. The initiator must drop req in the ack cycle to avoid a duplicate.
- Changes to Address, Datain, wr or size while busy are ignored (captured values are used).

Optional Feature:
- Macro MEM_RESP_MISALIGN_EN.
- Defined: at accept, the request is misaligned if (size=word and Address[1:0]≠0) or (size=halfword and Address[0]≠0). The request still traverses WAIT; misaligned writes perform no array write (MERGE skipped); misaligned reads leave Dataout unchanged. RESP asserts ack=1 with err=1. err equals 0 outside RESP.
- Undefined: err is tied to 0. Low address bits are silently ignored for word accesses; halfword lane is taken from Address[1].

Decomposition:
- Shared package mem_resp_pkg holds:
  - typedef enum of the FSM states;
  - typedef enum for size (SIZE_WORD=0, SIZE_BYTE=1, SIZE_HALF=2);
  - a localparam function for index width (log2 of DEPTH_WORDS).
- One natural sub-module: mem_resp_merge (combinational lane merge of old word, new data, size, Address[1:0]), reused by any future store path.

Test Plan:
- Reset then word write 0xDEADBEEF @0x10, LATENCY=1 → ack 3 cycles after req, err=0; read @0x10 returns Dataout=0xDEADBEEF.
- Byte write 0x5A @0x13 over word 0x11223344 → ack 4 cycles after req; read @0x10 returns 0x5A223344.
- Halfword write 0xBEEF @0x12 over 0x00000000 → read returns 0xBEEF0000; halfword write 0x1234 @0x10 → read returns 0xBEEF1234.
- LATENCY=4, read @0x400 with DEPTH_WORDS=256 → wraps to word 0; ack 6 cycles after req. busy stays high from the accept edge until the ack cycle; requests raised while busy are not accepted.
- reset pulsed low during WAIT of a word write 0xCAFEF00D @0x20 → ack never asserts, busy=0 immediately; read @0x20 returns the prior value.
- With MEM_RESP_MISALIGN_EN: word write @0x21 → ack with err=1, memory unchanged. Without the macro, the same write lands at word 0x20 with err=0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared FSM/size types and index-width helper for mem_responder
package mem_resp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ACCESS,
      MERGE,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      SIZE_WORD = 2'd0,
      SIZE_BYTE = 2'd1,
      SIZE_HALF = 2'd2
   } size_t;

   function automatic int idx_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/mem_resp_merge.sv
// rtl/mem_resp_merge.sv - little-endian byte/halfword lane merge into a 32-bit word
module mem_resp_merge
   import mem_resp_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   always_comb begin
      merged = new_data;
      case (size)
         SIZE_BYTE: begin
            merged = old_word;
            merged[{lane, 3'b000} +: 8] = new_data[7:0];
         end
         SIZE_HALF: begin
            merged = old_word;
            merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
         end
         default: merged = new_data;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - req/ack memory responder with wait states and sub-word RMW stores
// Optional misalignment error reporting: define MEM_RESP_MISALIGN_EN.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 1
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [31:0] Address,
   input  logic [31:0] Datain,
   input  logic [1:0]  size,
   output logic [31:0] Dataout,
   output logic        ack,
   output logic        busy,
   output logic        err
);

   localparam int IDX_W = idx_width(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_t             state, next;
   logic [CNT_W-1:0]   cnt;
   logic               wr_q;
   logic [IDX_W+1:0]   addr_q;
   logic [31:0]        data_q;
   logic [1:0]         size_q;
   logic               mis_q;
   logic               sub_q;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        mem [DEPTH_WORDS];
   logic [31:0]        rdata;
   logic [31:0]        merged;
   logic [31:0]        wdata;
   logic               mem_we;
   logic               unused_addr;

   assign idx         = addr_q[IDX_W+1:2];
   assign sub_q       = (size_q == SIZE_BYTE) || (size_q == SIZE_HALF);
   assign unused_addr = ^Address[31:IDX_W+2];

   mem_resp_merge u_merge (
      .old_word (rdata),
      .new_data (data_q),
      .size     (size_q),
      .lane     (addr_q[1:0]),
      .merged   (merged)
   );

`ifdef MEM_RESP_MISALIGN_EN
   logic mis_in;

   // Reserved size 3 behaves as a word access, so it must be word-aligned too.
   always_comb begin
      mis_in = 1'b0;
      if (size == SIZE_HALF)
         mis_in = Address[0];
      else if (size != SIZE_BYTE)
         mis_in = |Address[1:0];
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset)
         mis_q <= 1'b0;
      else if (state == IDLE && req)
         mis_q <= mis_in;
   end
`else
   assign mis_q = 1'b0;
`endif

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next;
   end

   always_comb begin
      next   = state;
      ack    = 1'b0;
      err    = 1'b0;
      busy   = (state != IDLE);
      mem_we = 1'b0;
      wdata  = data_q;
      case (state)
         IDLE:   if (req) next = WAIT;
         WAIT:   if (cnt == '0) next = ACCESS;
         ACCESS: begin
            mem_we = wr_q && !sub_q && !mis_q;
            next   = (wr_q && sub_q && !mis_q) ? MERGE : RESP;
         end
         MERGE: begin
            mem_we = 1'b1;
            wdata  = merged;
            next   = RESP;
         end
         RESP: begin
            ack  = 1'b1;
            err  = mis_q;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= 2'd0;
         Dataout <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               wr_q   <= wr;
               addr_q <= Address[IDX_W+1:0];
               data_q <= Datain;
               size_q <= size;
               cnt    <= CNT_INIT;
            end
            WAIT:   if (cnt != '0) cnt <= cnt - 1'b1;
            // Dataout is loaded alongside the array read so it is valid during ack.
            ACCESS: if (!wr_q && !mis_q) Dataout <= mem[idx];
            default: ;
         endcase
      end
   end

   // Array is deliberately left out of reset.
   always_ff @(posedge Clk) begin
      if (mem_we)
         mem[idx] <= wdata;
      if (state == ACCESS)
         rdata <= mem[idx];
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (LATENCY=1 and LATENCY=4 instances)
module tb_mem_responder;

   localparam int L0 = 1;
   localparam int L1 = 4;

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  sz;
      logic [31:0] rexp;
   } op_t;

   typedef struct {
      int          lat;
      logic        err;
      logic [31:0] dout;
   } exp_t;

   logic        Clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, wr = 1'b0;
   logic [31:0] Address = '0, Datain = '0;
   logic [1:0]  size = 2'd0;
   logic [31:0] dout0, dout1;
   logic        ack0, ack1, busy0, busy1, err0, err1;
   bit          sel = 1'b0;

   wire         ack_s  = sel ? ack1  : ack0;
   wire         busy_s = sel ? busy1 : busy0;
   wire         err_s  = sel ? err1  : err0;
   wire [31:0]  dout_s = sel ? dout1 : dout0;

   int          n_tests = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   op_t         ops_q[$];
   logic [31:0] model0 [8];
   logic [31:0] last0 = '0;
   logic [31:0] last1 = '0;

   mem_responder #(.DEPTH_WORDS(256), .LATENCY(L0)) u0 (
      .Clk(Clk), .reset(reset), .req(req0), .wr(wr), .Address(Address), .Datain(Datain),
      .size(size), .Dataout(dout0), .ack(ack0), .busy(busy0), .err(err0)
   );

   mem_responder #(.DEPTH_WORDS(256), .LATENCY(L1)) u1 (
      .Clk(Clk), .reset(reset), .req(req1), .wr(wr), .Address(Address), .Datain(Datain),
      .size(size), .Dataout(dout1), .ack(ack1), .busy(busy1), .err(err1)
   );

   always #5 Clk = ~Clk;

   function automatic op_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [1:0] sz, logic [31:0] rexp);
      op_t o;
      o.w = w; o.a = a; o.d = d; o.sz = sz; o.rexp = rexp;
      return o;
   endfunction

   function automatic logic [31:0] model_store(logic [31:0] old, logic [31:0] d, logic [1:0] sz, logic [1:0] lane);
      logic [31:0] m;
      m = old;
      if (sz == 2'd1)      m[lane*8 +: 8] = d[7:0];
      else if (sz == 2'd2) m[lane[1]*16 +: 16] = d[15:0];
      else                 m = d;
      return m;
   endfunction

   // Drives one request, holds req until ack, scrambles inputs while busy, returns observations.
   task automatic txn(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, output int lat, output logic [31:0] dout,
                      output logic e, output bit busy_ok);
      sel = s; wr = w; Address = a; Datain = d; size = sz;
      if (s) req1 = 1'b1; else req0 = 1'b1;
      @(posedge Clk); #1;
      Address = ~a; Datain = ~d; wr = ~w; size = ~sz;
      lat = -1; busy_ok = 1'b1; dout = 'x; e = 'x;
      for (int n = 1; n <= 40; n++) begin
         if (busy_s !== 1'b1) busy_ok = 1'b0;
         @(posedge Clk); #1;
         if (ack_s === 1'b1) begin
            if (busy_s !== 1'b1) busy_ok = 1'b0;
            lat = n; dout = dout_s; e = err_s;
            break;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_reset();
      #12;
      n_tests++;
      if ({ack0, busy0, err0} !== 3'b000) begin n_fail++; $display("FAIL reset_u0_flags: got %b want 000", {ack0, busy0, err0}); end
      n_tests++;
      if (dout0 !== 32'h0) begin n_fail++; $display("FAIL reset_u0_dout: got %h want 00000000", dout0); end
      n_tests++;
      if ({ack1, busy1, err1} !== 3'b000) begin n_fail++; $display("FAIL reset_u1_flags: got %b want 000", {ack1, busy1, err1}); end
      n_tests++;
      if (dout1 !== 32'h0) begin n_fail++; $display("FAIL reset_u1_dout: got %h want 00000000", dout1); end
      @(negedge Clk); reset = 1'b1;
      @(posedge Clk); #1;
   endtask

   task automatic test_word_and_subword();
      int lat; logic [31:0] dout; logic er; bit bok; exp_t e;
      ops_q = {};
      ops_q.push_back(mk(1, 32'h10, 32'hDEADBEEF, 2'd0, 0));
      ops_q.push_back(mk(0, 32'h10, 32'h0,        2'd0, 32'hDEADBEEF));
      ops_q.push_back(mk(1, 32'h10, 32'h11223344, 2'd0, 0));
      ops_q.push_back(mk(1, 32'h13, 32'hFFFFFF5A, 2'd1, 0));
      ops_q.push_back(mk(0, 32'h10, 32'h0,        2'd3, 32'h5A223344));
      ops_q.push_back(mk(1, 32'h10, 32'h00000000, 2'd0, 0));
      ops_q.push_back(mk(1, 32'h12, 32'h7777BEEF, 2'd2, 0));
      ops_q.push_back(mk(0, 32'h10, 32'h0,        2'd1, 32'hBEEF0000));
      ops_q.push_back(mk(1, 32'h10, 32'h99991234, 2'd2, 0));
      ops_q.push_back(mk(0, 32'h10, 32'h0,        2'd0, 32'hBEEF1234));
      foreach (ops_q[i]) begin
         e.lat  = L0 + 1 + ((ops_q[i].w && (ops_q[i].sz == 2'd1 || ops_q[i].sz == 2'd2)) ? 1 : 0);
         e.err  = 1'b0;
         e.dout = ops_q[i].w ? last0 : ops_q[i].rexp;
         sb.push_back(e);
         txn(0, ops_q[i].w, ops_q[i].a, ops_q[i].d, ops_q[i].sz, lat, dout, er, bok);
         e = sb.pop_front();
         if (!ops_q[i].w) last0 = ops_q[i].rexp;
         n_tests++;
         if (lat !== e.lat) begin n_fail++; $display("FAIL dir[%0d]_lat: got %0d want %0d", i, lat, e.lat); end
         n_tests++;
         if (er !== e.err) begin n_fail++; $display("FAIL dir[%0d]_err: got %b want %b", i, er, e.err); end
         n_tests++;
         if (dout !== e.dout) begin n_fail++; $display("FAIL dir[%0d]_dout: got %h want %h", i, dout, e.dout); end
         n_tests++;
         if (!bok) begin n_fail++; $display("FAIL dir[%0d]_busy: got 0 want 1 while pending", i); end
      end
   endtask

   task automatic test_latency4_wrap();
      int lat; logic [31:0] dout; logic er; bit bok; exp_t e; bit extra;
      e.lat = L1 + 1; e.err = 1'b0; e.dout = last1;
      sb.push_back(e);
      txn(1, 1, 32'h0, 32'h13579BDF, 2'd0, lat, dout, er, bok);
      e = sb.pop_front();
      n_tests++;
      if (lat !== e.lat || dout !== e.dout) begin n_fail++; $display("FAIL lat4_wr: got lat %0d dout %h want lat %0d dout %h", lat, dout, e.lat, e.dout); end
      e.lat = L1 + 1; e.err = 1'b0; e.dout = 32'h13579BDF;
      sb.push_back(e);
      txn(1, 0, 32'h400, 32'h0, 2'd0, lat, dout, er, bok);
      e = sb.pop_front();
      last1 = 32'h13579BDF;
      n_tests++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL lat4_rd_lat: got %0d want %0d", lat, e.lat); end
      n_tests++;
      if (dout !== e.dout) begin n_fail++; $display("FAIL lat4_wrap_dout: got %h want %h", dout, e.dout); end
      n_tests++;
      if (!bok || er !== 1'b0) begin n_fail++; $display("FAIL lat4_busy_err: got busy_ok %b err %b want 1 0", bok, er); end
      extra = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (ack1 !== 1'b0 || busy1 !== 1'b0) extra = 1'b1;
         @(posedge Clk); #1;
      end
      n_tests++;
      if (extra) begin n_fail++; $display("FAIL lat4_idle_after: got ack/busy activity want none"); end
   endtask

   task automatic test_misalign();
      int lat; logic [31:0] dout; logic er; bit bok; exp_t e;
      logic [31:0] want_rd; logic want_err;
`ifdef MEM_RESP_MISALIGN_EN
      want_rd = 32'h11111111; want_err = 1'b1;
`else
      want_rd = 32'hA5A5A5A5; want_err = 1'b0;
`endif
      txn(0, 1, 32'h20, 32'h11111111, 2'd0, lat, dout, er, bok);
      e.lat = L0 + 1; e.err = want_err; e.dout = last0;
      sb.push_back(e);
      txn(0, 1, 32'h21, 32'hA5A5A5A5, 2'd0, lat, dout, er, bok);
      e = sb.pop_front();
      n_tests++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL mis_lat: got %0d want %0d", lat, e.lat); end
      n_tests++;
      if (er !== e.err) begin n_fail++; $display("FAIL mis_err: got %b want %b", er, e.err); end
      n_tests++;
      if (err0 !== 1'b0) begin n_fail++; $display("FAIL mis_err_idle: got %b want 0", err0); end
      e.lat = L0 + 1; e.err = 1'b0; e.dout = want_rd;
      sb.push_back(e);
      txn(0, 0, 32'h20, 32'h0, 2'd0, lat, dout, er, bok);
      e = sb.pop_front();
      last0 = want_rd;
      n_tests++;
      if (dout !== e.dout || er !== e.err) begin n_fail++; $display("FAIL mis_readback: got %h err %b want %h err %b", dout, er, e.dout, e.err); end
   endtask

   task automatic test_random();
      int lat; logic [31:0] dout; logic er; bit bok; exp_t e;
      bit w; int k; logic [1:0] sz, lane; logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         model0[i] = d;
         txn(0, 1, 32'(i * 4), d, 2'd0, lat, dout, er, bok);
      end
      for (int i = 0; i < 24; i++) begin
         w = 1'($urandom_range(1));
         k = $urandom_range(7);
         sz = 2'($urandom_range(2));
         d = $urandom;
         lane = 2'($urandom_range(3));
         if (sz == 2'd0 || !w) lane = 2'd0;
         else if (sz == 2'd2) lane[0] = 1'b0;
         e.lat = L0 + 1 + ((w && sz != 2'd0) ? 1 : 0);
         e.err = 1'b0;
         if (w) begin
            e.dout = last0;
            model0[k] = model_store(model0[k], d, sz, lane);
         end else begin
            e.dout = model0[k];
            last0 = model0[k];
         end
         sb.push_back(e);
         txn(0, w, {26'h0, 3'(k), lane}, d, sz, lat, dout, er, bok);
         e = sb.pop_front();
         n_tests++;
         if (lat !== e.lat || er !== e.err || dout !== e.dout || !bok)
            begin n_fail++; $display("FAIL rnd[%0d]: got lat %0d err %b dout %h busy_ok %b want lat %0d err %b dout %h", i, lat, er, dout, bok, e.lat, e.err, e.dout); end
      end
   endtask

   task automatic test_reset_abort();
      int lat; logic [31:0] dout; logic er; bit bok; bit seen;
      txn(1, 1, 32'h20, 32'h0BADF00D, 2'd0, lat, dout, er, bok);
      sel = 1'b1; wr = 1'b1; Address = 32'h20; Datain = 32'hCAFEF00D; size = 2'd0; req1 = 1'b1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      reset = 1'b0;
      #1;
      n_tests++;
      if (busy1 !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got busy %b ack %b want 0 0", busy1, ack1); end
      n_tests++;
      if (dout1 !== 32'h0) begin n_fail++; $display("FAIL abort_dout: got %h want 00000000", dout1); end
      req1 = 1'b0;
      last0 = '0; last1 = '0;
      @(negedge Clk); reset = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(posedge Clk); #1;
         if (ack1 !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL abort_no_ack: got ack want none"); end
      txn(1, 0, 32'h20, 32'h0, 2'd0, lat, dout, er, bok);
      n_tests++;
      if (dout !== 32'h0BADF00D || lat !== L1 + 1) begin n_fail++; $display("FAIL abort_readback: got %h lat %0d want 0badf00d lat %0d", dout, lat, L1 + 1); end
   endtask

   initial begin
      test_reset();
      test_word_and_subword();
      test_latency4_wrap();
      test_misalign();
      test_random();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
